// File: rtl/rotor_shift_engine_pkg.sv
// Shared constants for the rotor shift path: default alphabet and field widths, plus the per-char mode encoding.
package rotor_shift_engine_pkg;

    localparam int DEF_ALPHA_SIZE = 26;
    localparam int DEF_CHAR_W     = 7;
    localparam int DEF_NUM_ROTORS = 3;
    localparam int DEF_ROTOR_W    = 5;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_ENC = 1'b1
    } mode_e;

endpackage

// File: rtl/rotor_shift_engine_stage.sv
// One registered mod-ALPHA_SIZE add/sub stage; uses its own rotor field of the carried position snapshot.
module rotor_shift_stage
    import rotor_shift_engine_pkg::*;
#(
    parameter int ALPHA_SIZE = DEF_ALPHA_SIZE,
    parameter int CHAR_W     = DEF_CHAR_W,
    parameter int NUM_ROTORS = DEF_NUM_ROTORS,
    parameter int ROTOR_W    = DEF_ROTOR_W,
    parameter int STAGE      = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_hold,
    input  logic                          i_valid,
    input  logic [CHAR_W-1:0]             i_value,
    input  logic                          i_enc,
    input  logic                          i_err,
    input  logic [NUM_ROTORS*ROTOR_W-1:0] i_pos,
    output logic                          o_valid,
    output logic [CHAR_W-1:0]             o_value,
    output logic                          o_enc,
    output logic                          o_err,
    output logic [NUM_ROTORS*ROTOR_W-1:0] o_pos
);

    localparam int SUM_W = ((CHAR_W > ROTOR_W) ? CHAR_W : ROTOR_W) + 1;

    logic [SUM_W-1:0] w_v, w_p, w_sum, w_dif, w_res;

    // Both operands are already < ALPHA_SIZE, so one conditional correction is enough.
    always_comb begin
        w_v   = SUM_W'(i_value);
        w_p   = SUM_W'(i_pos[STAGE*ROTOR_W +: ROTOR_W]);
        w_sum = w_v + w_p;
        if (w_sum >= SUM_W'(ALPHA_SIZE))
            w_sum = w_sum - SUM_W'(ALPHA_SIZE);
        w_dif = w_v - w_p;
        if (w_v < w_p)
            w_dif = w_dif + SUM_W'(ALPHA_SIZE);
        w_res = (mode_e'(i_enc) == MODE_ENC) ? w_sum : w_dif;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_value <= '0;
            o_enc   <= 1'b0;
            o_err   <= 1'b0;
            o_pos   <= '0;
        end else if (!i_hold) begin
            o_valid <= i_valid;
            o_value <= i_err ? i_value : CHAR_W'(w_res);
            o_enc   <= i_enc;
            o_err   <= i_err;
            o_pos   <= i_pos;
        end
    end

endmodule

// File: rtl/rotor_shift_engine.sv
// Pipelined multi-rotor shift path: odometer position registers, handshake, and one shift stage per rotor.
module rotor_shift_engine
    import rotor_shift_engine_pkg::*;
#(
    parameter int ALPHA_SIZE = DEF_ALPHA_SIZE,
    parameter int CHAR_W     = DEF_CHAR_W,
    parameter int NUM_ROTORS = DEF_NUM_ROTORS,
    parameter int ROTOR_W    = DEF_ROTOR_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_pos,
    input  logic [NUM_ROTORS*ROTOR_W-1:0] pos_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHAR_W-1:0]             char_in,
    input  logic                          encrypt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHAR_W-1:0]             char_out,
    output logic                          out_err,
    output logic [NUM_ROTORS*ROTOR_W-1:0] pos_out
);

    logic [NUM_ROTORS-1:0][ROTOR_W-1:0] r_pos, w_pos_step, w_pos_load;
    logic w_stall, w_accept, w_in_range, w_carry;

    logic [NUM_ROTORS:0]                              w_vld_pipe;
    logic [NUM_ROTORS:0][CHAR_W-1:0]                  w_val;
    logic [NUM_ROTORS:0]                              w_enc, w_err;
    logic [NUM_ROTORS:0][NUM_ROTORS*ROTOR_W-1:0]      w_pos_pipe;
    logic                                             w_unused;

    assign w_stall    = out_valid && !out_ready;
    assign in_ready   = !reset && !w_stall && !load_pos;
    assign w_accept   = in_valid && in_ready;
    assign w_in_range = char_in < CHAR_W'(ALPHA_SIZE);

    // Odometer step: a rotor advances only while every lower rotor is wrapping.
    always_comb begin
        w_pos_step = r_pos;
        w_carry    = 1'b1;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (w_carry) begin
                if (r_pos[i] == ROTOR_W'(ALPHA_SIZE - 1)) begin
                    w_pos_step[i] = '0;
                end else begin
                    w_pos_step[i] = r_pos[i] + ROTOR_W'(1);
                    w_carry       = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_pos_load = pos_in;
        for (int i = 0; i < NUM_ROTORS; i++)
            if (pos_in[i*ROTOR_W +: ROTOR_W] >= ROTOR_W'(ALPHA_SIZE))
                w_pos_load[i] = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pos <= '0;
        else if (load_pos)
            r_pos <= w_pos_load;
        else if (w_accept && w_in_range)
            r_pos <= w_pos_step;
    end

    assign w_vld_pipe[0] = w_accept;
    assign w_val[0]      = char_in;
    assign w_enc[0]      = encrypt;
    assign w_err[0]      = !w_in_range;
    assign w_pos_pipe[0] = w_pos_step;

    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_stage
        rotor_shift_stage #(
            .ALPHA_SIZE (ALPHA_SIZE),
            .CHAR_W     (CHAR_W),
            .NUM_ROTORS (NUM_ROTORS),
            .ROTOR_W    (ROTOR_W),
            .STAGE      (g)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .i_hold  (w_stall),
            .i_valid (w_vld_pipe[g]),
            .i_value (w_val[g]),
            .i_enc   (w_enc[g]),
            .i_err   (w_err[g]),
            .i_pos   (w_pos_pipe[g]),
            .o_valid (w_vld_pipe[g+1]),
            .o_value (w_val[g+1]),
            .o_enc   (w_enc[g+1]),
            .o_err   (w_err[g+1]),
            .o_pos   (w_pos_pipe[g+1])
        );
    end

    assign out_valid = w_vld_pipe[NUM_ROTORS];
    assign char_out  = w_val[NUM_ROTORS];
    assign out_err   = w_err[NUM_ROTORS];
    assign pos_out   = r_pos;
    assign w_unused  = ^{w_enc[NUM_ROTORS], w_pos_pipe[NUM_ROTORS]};

endmodule

// File: tb/tb_rotor_shift_engine.sv
// Scoreboard bench for rotor_shift_engine: directed vectors plus an encrypt/decrypt round trip.
module tb_rotor_shift_engine;

    localparam int A  = 26;
    localparam int CW = 7;
    localparam int NR = 3;
    localparam int RW = 5;

    logic              clock = 1'b0;
    logic              reset, load_pos, in_valid, encrypt, out_ready;
    logic              in_ready, out_valid, out_err;
    logic [NR*RW-1:0]  pos_in, pos_out;
    logic [CW-1:0]     char_in, char_out;

    rotor_shift_engine dut (
        .clock(clock), .reset(reset), .load_pos(load_pos), .pos_in(pos_in),
        .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in), .encrypt(encrypt),
        .out_valid(out_valid), .out_ready(out_ready), .char_out(char_out),
        .out_err(out_err), .pos_out(pos_out)
    );

    always #5 clock = ~clock;

    typedef struct { int ch; bit err; } exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   m_pos[NR];
    int   last_exp;
    int   q_in[$], q_enc[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_pos();
        logic [NR*RW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = RW'(m_pos[i]);
        return int'(v);
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("char_out", int'(char_out), e.ch);
                    chk("out_err", int'(out_err), int'(e.err));
                end
            end
        end
    end

    // exp < 0 means take the expected letter from the reference model
    task automatic send(int c, bit enc, int exp);
        bit ok;
        int sum, carry, mval;
        exp_t e;
        ok = 0;
        in_valid = 1'b1; char_in = CW'(c); encrypt = enc;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                if (c < A) begin
                    carry = 1;
                    for (int i = 0; i < NR; i++)
                        if (carry != 0) begin
                            if (m_pos[i] == A - 1) m_pos[i] = 0;
                            else begin m_pos[i]++; carry = 0; end
                        end
                    sum = 0;
                    for (int i = 0; i < NR; i++) sum += m_pos[i];
                    mval = enc ? (c + sum) % A : (((c - sum) % A) + A) % A;
                end else mval = c;
                last_exp = mval;
                e.ch  = (exp >= 0) ? exp : mval;
                e.err = (c >= A);
                sb.push_back(e);
            end
            @(posedge clock); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else chk("pos_out_after_accept", int'(pos_out), model_pos());
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic load(int p0, int p1, int p2);
        load_pos = 1'b1;
        pos_in = {RW'(p2), RW'(p1), RW'(p0)};
        @(negedge clock);
        chk("in_ready_during_load", int'(in_ready), 0);
        @(posedge clock); #1;
        load_pos = 1'b0;
        m_pos[0] = (p0 >= A) ? 0 : p0;
        m_pos[1] = (p1 >= A) ? 0 : p1;
        m_pos[2] = (p2 >= A) ? 0 : p2;
        chk("pos_after_load", int'(pos_out), model_pos());
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clock);
        @(posedge clock); #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        reset = 1'b1; load_pos = 1'b0; pos_in = '0; in_valid = 1'b0;
        char_in = '0; encrypt = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NR; i++) m_pos[i] = 0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_char_out", int'(char_out), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_pos_out", int'(pos_out), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        chk("in_ready_after_release", int'(in_ready), 1);

        // 1: single step, three-edge latency
        load(0, 0, 0);
        send(0, 1'b1, 1);
        idle();
        chk("t1_pos", int'(pos_out), 1);
        @(negedge clock);
        @(negedge clock);
        chk("t1_out_valid_early", int'(out_valid), 0);
        @(negedge clock);
        chk("t1_out_valid_latency", int'(out_valid), 1);
        chk("t1_char_out", int'(char_out), 1);
        drain();

        // 2: rotor0 wraps, rotor1 steps
        load(25, 0, 0);
        send(25, 1'b1, 0);
        idle();
        chk("t2_pos", int'(pos_out), 1 << RW);
        drain();

        // 3: double carry
        load(25, 25, 0);
        send(0, 1'b1, 1);
        idle();
        chk("t3_pos", int'(pos_out), 1 << (2*RW));
        drain();

        // 4: decrypt borrow
        load(25, 0, 0);
        send(0, 1'b0, 25);
        idle();
        drain();

        // out-of-range load fields clamp to 0
        load(30, 3, 26);
        chk("load_clamp", int'(pos_out), 3 << RW);

        // round trip from a common start
        load(7, 19, 25);
        for (int i = 0; i < 200; i++) begin
            p = $urandom_range(0, A-1);
            q_in.push_back(p);
            send(p, 1'b1, -1);
            q_enc.push_back(last_exp);
        end
        idle();
        drain();
        load(7, 19, 25);
        for (int i = 0; i < 200; i++) send(q_enc[i], 1'b0, q_in[i]);
        idle();
        drain();

        // 5: downstream stall mid-stream
        load(0, 0, 0);
        fork
            begin
                for (int i = 0; i < 10; i++) send(i + 3, 1'b1, -1);
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // 6: out-of-range char passes through with err, no step
        p = int'(pos_out);
        send(26, 1'b1, 26);
        idle();
        chk("t6_pos_unchanged", int'(pos_out), p);
        drain();

        // reset with two chars in flight
        load(0, 0, 0);
        send(3, 1'b1, -1);
        send(4, 1'b1, -1);
        idle();
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_pos", int'(pos_out), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        sb.delete();
        for (int i = 0; i < NR; i++) m_pos[i] = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("post_rst_no_output", int'(out_valid), 0);
        send(0, 1'b1, 1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
